// File: rtl/mips_pkg.sv
// Shared encodings for the execute stage: ALUOp classes, R-type funct codes
// and the internal ALU-control operation set.
package mips_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_RTYPE = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_SLT   = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_LUI   = 3'b111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI,
        ALU_ZERO
    } alu_ctrl_t;

endpackage

// File: rtl/execute_if.sv
// Operand/result bundle between the decode side (master) and the execute stage (slave).
interface execute_if;

    logic [31:0] ALUReadData1;
    logic [31:0] ALUReadData2;
    logic [31:0] immediate;
    logic [31:0] pc;
    logic [5:0]  funct;
    logic [2:0]  ALUOp;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        ALUSrc;
    logic        rgdst;
    logic [31:0] aluresult;
    logic        zero;
    logic [31:0] addresult;
    logic [31:0] alureaddata2;
    logic [4:0]  rd_or_rt;

    modport master (
        output ALUReadData1, ALUReadData2, immediate, pc, funct, ALUOp, rt, rd, ALUSrc, rgdst,
        input  aluresult, zero, addresult, alureaddata2, rd_or_rt
    );

    modport slave (
        input  ALUReadData1, ALUReadData2, immediate, pc, funct, ALUOp, rt, rd, ALUSrc, rgdst,
        output aluresult, zero, addresult, alureaddata2, rd_or_rt
    );

endinterface

// File: rtl/alu.sv
// Purely combinational 32-bit ALU driven by the decoded ALU-control operation.
module alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_ctrl_t   control,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'd0;
        case (control)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'd0, a < b};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
            ALU_LUI:  result = {b[15:0], 16'd0};
            default:  result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/execute.sv
// Execute stage: operand select, ALU-control decode, branch target adder,
// destination select, and a single output register stage.
module execute
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    execute_if.slave  bus
);

    logic [31:0] operand_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    alu_ctrl_t   alu_control;

    assign operand_b = bus.ALUSrc ? bus.immediate : bus.ALUReadData2;

    always_comb begin
        alu_control = ALU_ZERO;
        case (bus.ALUOp)
            OP_ADD: alu_control = ALU_ADD;
            OP_SUB: alu_control = ALU_SUB;
            OP_AND: alu_control = ALU_AND;
            OP_OR:  alu_control = ALU_OR;
            OP_SLT: alu_control = ALU_SLT;
            OP_XOR: alu_control = ALU_XOR;
            OP_LUI: alu_control = ALU_LUI;
            OP_RTYPE: begin
                case (bus.funct)
                    FN_ADD, FN_ADDU: alu_control = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_control = ALU_SUB;
                    FN_AND:          alu_control = ALU_AND;
                    FN_OR:           alu_control = ALU_OR;
                    FN_XOR:          alu_control = ALU_XOR;
                    FN_NOR:          alu_control = ALU_NOR;
                    FN_SLT:          alu_control = ALU_SLT;
                    FN_SLTU:         alu_control = ALU_SLTU;
                    FN_SLL:          alu_control = ALU_SLL;
                    FN_SRL:          alu_control = ALU_SRL;
                    FN_SRA:          alu_control = ALU_SRA;
                    default:         alu_control = ALU_ZERO;
                endcase
            end
            default: alu_control = ALU_ZERO;
        endcase
    end

    alu u_alu (
        .a       (bus.ALUReadData1),
        .b       (operand_b),
        .shamt   (bus.immediate[10:6]),
        .control (alu_control),
        .result  (alu_result),
        .zero    (alu_zero)
    );

    // Reset value of zero is 1 so it stays consistent with the cleared result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.aluresult    <= 32'd0;
            bus.zero         <= 1'b1;
            bus.addresult    <= 32'd0;
            bus.alureaddata2 <= 32'd0;
            bus.rd_or_rt     <= 5'd0;
        end else begin
            bus.aluresult    <= alu_result;
            bus.zero         <= alu_zero;
            bus.addresult    <= bus.pc + {bus.immediate[29:0], 2'b00};
            bus.alureaddata2 <= bus.ALUReadData2;
            bus.rd_or_rt     <= bus.rgdst ? bus.rd : bus.rt;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed corner cases plus randomized
// instructions compared against a behavioural model of the stage.
module tb_execute;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_a1, m_a2, m_imm, m_pc;
    logic [5:0]  m_funct;
    logic [2:0]  m_op;
    logic [4:0]  m_rt, m_rd;
    logic        m_alusrc, m_rgdst;

    execute_if bus();

    execute dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a ^ b;
            3'd7: return b * 32'd65536;
            default: begin
                case (f)
                    6'h20, 6'h21: return a + b;
                    6'h22, 6'h23: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h26: return a ^ b;
                    6'h27: return ~(a | b);
                    6'h2a: return (sa < sb) ? 32'd1 : 32'd0;
                    6'h2b: return (a < b) ? 32'd1 : 32'd0;
                    6'h00: return b << sh;
                    6'h02: return b >> sh;
                    6'h03: return $unsigned(sb >>> sh);
                    default: return 32'd0;
                endcase
            end
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one instruction on the falling edge, then sample just after the capturing edge.
    task automatic apply_stimulus(input logic [31:0] a1, input logic [31:0] a2,
                                  input logic [31:0] imm, input logic [31:0] pcv,
                                  input logic [5:0] f, input logic [2:0] op,
                                  input logic [4:0] rtv, input logic [4:0] rdv,
                                  input logic alusrc, input logic rgdst);
        @(negedge clk);
        bus.ALUReadData1 = a1;  bus.ALUReadData2 = a2;
        bus.immediate    = imm; bus.pc           = pcv;
        bus.funct        = f;   bus.ALUOp        = op;
        bus.rt           = rtv; bus.rd           = rdv;
        bus.ALUSrc       = alusrc; bus.rgdst     = rgdst;
        m_a1 = a1; m_a2 = a2; m_imm = imm; m_pc = pcv; m_funct = f; m_op = op;
        m_rt = rtv; m_rd = rdv; m_alusrc = alusrc; m_rgdst = rgdst;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_res;
        exp_res = ref_alu(m_op, m_funct, m_a1, m_alusrc ? m_imm : m_a2, m_imm[10:6]);
        check_output({tag, "_alu"},  bus.aluresult, exp_res);
        check_output({tag, "_zero"}, {31'd0, bus.zero}, (exp_res == 32'd0) ? 32'd1 : 32'd0);
        check_output({tag, "_add"},  bus.addresult, m_pc + m_imm * 32'd4);
        check_output({tag, "_sd"},   bus.alureaddata2, m_a2);
        check_output({tag, "_dst"},  {27'd0, bus.rd_or_rt}, {27'd0, m_rgdst ? m_rd : m_rt});
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_alu"},  bus.aluresult, 32'd0);
        check_output({tag, "_zero"}, {31'd0, bus.zero}, 32'd1);
        check_output({tag, "_add"},  bus.addresult, 32'd0);
        check_output({tag, "_sd"},   bus.alureaddata2, 32'd0);
        check_output({tag, "_dst"},  {27'd0, bus.rd_or_rt}, 32'd0);
    endtask

    initial begin
        logic [5:0] fn_table [14];
        logic [31:0] a1, a2;
        logic [5:0]  f;
        logic [2:0]  op;
        fn_table = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                     6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h3f};

        bus.ALUReadData1 = 32'h1234_5678; bus.ALUReadData2 = 32'h9abc_def0;
        bus.immediate = 32'h55; bus.pc = 32'h400; bus.funct = 6'h20; bus.ALUOp = 3'd0;
        bus.rt = 5'd3; bus.rd = 5'd4; bus.ALUSrc = 1'b0; bus.rgdst = 1'b1;

        // Reset held across clock edges must keep outputs cleared.
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        apply_stimulus(32'd5, 32'd3, 32'd10, 32'd0, 6'h00, 3'd0, 5'd9, 5'd17, 1'b0, 1'b0);
        check_output("add_alu", bus.aluresult, 32'd8);
        check_output("add_zero", {31'd0, bus.zero}, 32'd0);
        check_output("add_target", bus.addresult, 32'd40);
        check_output("add_sd", bus.alureaddata2, 32'd3);
        check_output("add_dst", {27'd0, bus.rd_or_rt}, 32'd9);

        // Inputs changing mid-cycle must not reach the outputs.
        #2 bus.ALUReadData1 = 32'd100; bus.rgdst = 1'b1;
        #1 check_output("hold_alu", bus.aluresult, 32'd8);
        check_output("hold_dst", {27'd0, bus.rd_or_rt}, 32'd9);

        apply_stimulus(32'd5, 32'd3, 32'd10, 32'd0, 6'h00, 3'd0, 5'd9, 5'd17, 1'b1, 1'b1);
        check_output("addi_alu", bus.aluresult, 32'd15);
        check_output("rd_dst", {27'd0, bus.rd_or_rt}, 32'd17);

        apply_stimulus(32'd7, 32'd7, 32'd0, 32'd0, 6'h00, 3'd1, 5'd1, 5'd2, 1'b0, 1'b0);
        check_output("sub_zero_alu", bus.aluresult, 32'd0);
        check_output("sub_zero_flag", {31'd0, bus.zero}, 32'd1);

        apply_stimulus(32'd3, 32'd5, 32'd0, 32'd0, 6'b100010, 3'd2, 5'd1, 5'd2, 1'b0, 1'b1);
        check_output("rsub_wrap", bus.aluresult, 32'hFFFF_FFFE);
        apply_stimulus(32'd3, 32'd5, 32'd0, 32'd0, 6'b101010, 3'd2, 5'd1, 5'd2, 1'b0, 1'b1);
        check_output("rslt", bus.aluresult, 32'd1);
        apply_stimulus(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 6'b101011, 3'd2, 5'd1, 5'd2, 1'b0, 1'b1);
        check_output("rsltu", bus.aluresult, 32'd0);
        apply_stimulus(32'd0, 32'h8000_0000, 32'h100, 32'd0, 6'b000011, 3'd2, 5'd1, 5'd2, 1'b0, 1'b1);
        check_output("rsra", bus.aluresult, 32'hF800_0000);
        apply_stimulus(32'd0, 32'h8000_0000, 32'h100, 32'd0, 6'b000010, 3'd2, 5'd1, 5'd2, 1'b0, 1'b1);
        check_output("rsrl", bus.aluresult, 32'h0800_0000);
        apply_stimulus(32'd0, 32'd1, 32'hFFFF_FFFF, 32'h100, 6'h00, 3'd0, 5'd9, 5'd17, 1'b0, 1'b0);
        check_output("neg_target", bus.addresult, 32'h0000_00FC);
        check_output("rt_dst", {27'd0, bus.rd_or_rt}, 32'd9);
        check_model("neg_model");

        // Asynchronous reset between edges, then release and capture normally.
        apply_stimulus(32'd20, 32'd22, 32'd6, 32'h40, 6'h00, 3'd0, 5'd5, 5'd6, 1'b0, 1'b1);
        check_model("pre_rst");
        #2 rst_n = 1'b0;
        #1 check_reset_state("mid_rst");
        rst_n = 1'b1;
        apply_stimulus(32'd11, 32'd4, 32'd2, 32'h80, 6'h00, 3'd1, 5'd12, 5'd13, 1'b0, 1'b0);
        check_output("post_rst_alu", bus.aluresult, 32'd7);
        check_output("post_rst_target", bus.addresult, 32'h88);
        check_model("post_rst");

        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            f  = fn_table[$urandom_range(0, 13)];
            if ($urandom_range(0, 9) == 0) f = 6'($urandom);
            a1 = $urandom;
            a2 = ($urandom_range(0, 7) == 0) ? a1 : $urandom;
            if ($urandom_range(0, 3) == 0) a1 = {{16{a1[15]}}, a1[15:0]};
            apply_stimulus(a1, a2, $urandom, $urandom, f, op, 5'($urandom), 5'($urandom),
                           1'($urandom), 1'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
